// File: rtl/lc3b_types.sv
// Shared LC-3b types: memory word, cache line and the L2 arbiter state encoding.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_pmem_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_l2_arb_state;

endpackage

// File: rtl/l2_arb_select.sv
// Winner selection for the L2 arbiter. D-cache normally wins a tie, but after
// MAX_D_STREAK back-to-back D grants with the I-cache still waiting, the
// I-cache is given the next grant so it cannot starve.
module l2_arb_select
    import lc3b_types::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic arb,
    output logic pick_i
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak;

    // I wins when it is alone, or when the D streak has reached its limit.
    always_comb begin
        pick_i = i_req && (!d_req || (streak == STREAK_MAX));
    end

    // Count D grants made while an I request waits; any other grant restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (arb) begin
            if (!pick_i && i_req) begin
                if (streak != STREAK_MAX) begin
                    streak <= streak + SW'(1);
                end
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Two-port L2 arbiter: shares one L2 memory port between the I-cache and the
// D-cache. Arbitration happens in IDLE; the grant is held until l2_mem_resp.
// Optional feature: define L2_ARB_PERF_EN to add per-port grant counters.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          icache_read,
    input  lc3b_word      icache_address,
    output logic          icache_resp,
    output lc3b_pmem_line icache_rdata,

    input  logic          dcache_read,
    input  logic          dcache_write,
    input  lc3b_word      dcache_address,
    input  lc3b_pmem_line dcache_wdata,
    output logic          dcache_resp,
    output lc3b_pmem_line dcache_rdata,

`ifdef L2_ARB_PERF_EN
    output lc3b_word      i_grant_count,
    output lc3b_word      d_grant_count,
`endif

    output logic          l2_mem_read,
    output logic          l2_mem_write,
    output lc3b_word      l2_mem_address,
    output lc3b_pmem_line l2_mem_wdata,
    input  logic          l2_mem_resp,
    input  lc3b_pmem_line l2_mem_rdata
);

    lc3b_l2_arb_state state, state_next;
    logic d_req;
    logic arb;
    logic pick_i;

    assign d_req = dcache_read | dcache_write;
    assign arb   = (state == IDLE) && (icache_read || d_req);

    l2_arb_select #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_select (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req  (icache_read),
        .d_req  (d_req),
        .arb    (arb),
        .pick_i (pick_i)
    );

    // Read data is broadcast to both caches; resp alone marks it valid.
    assign icache_rdata = l2_mem_rdata;
    assign dcache_rdata = l2_mem_rdata;

    // State register; reset drops any grant in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and forwarding of the owner's request onto the L2 port.
    always_comb begin
        state_next     = state;
        l2_mem_read    = 1'b0;
        l2_mem_write   = 1'b0;
        l2_mem_address = '0;
        l2_mem_wdata   = '0;
        icache_resp    = 1'b0;
        dcache_resp    = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb) begin
                    state_next = pick_i ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I: begin
                l2_mem_read    = icache_read;
                l2_mem_address = icache_address;
                if (l2_mem_resp) begin
                    icache_resp = 1'b1;
                    state_next  = IDLE;
                end
            end
            SERVE_D: begin
                // A simultaneous read+write is treated as a write.
                l2_mem_write   = dcache_write;
                l2_mem_read    = dcache_read & ~dcache_write;
                l2_mem_address = dcache_address;
                l2_mem_wdata   = dcache_wdata;
                if (l2_mem_resp) begin
                    dcache_resp = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef L2_ARB_PERF_EN
    // Grant counters, bumped on the arbitration edge; wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_grant_count <= '0;
            d_grant_count <= '0;
        end else if (arb) begin
            if (pick_i) begin
                i_grant_count <= i_grant_count + 16'd1;
            end else begin
                d_grant_count <= d_grant_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter. Inputs change 1 time unit after a rising
// edge and outputs are checked within the same cycle, away from the edge.
`timescale 1ns/1ps
module tb_l2_arbiter;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          icache_read = 1'b0;
    lc3b_word      icache_address = '0;
    logic          icache_resp;
    lc3b_pmem_line icache_rdata;
    logic          dcache_read = 1'b0;
    logic          dcache_write = 1'b0;
    lc3b_word      dcache_address = '0;
    lc3b_pmem_line dcache_wdata = '0;
    logic          dcache_resp;
    lc3b_pmem_line dcache_rdata;
    logic          l2_mem_read;
    logic          l2_mem_write;
    lc3b_word      l2_mem_address;
    lc3b_pmem_line l2_mem_wdata;
    logic          l2_mem_resp = 1'b0;
    lc3b_pmem_line l2_mem_rdata = '0;
`ifdef L2_ARB_PERF_EN
    lc3b_word      i_grant_count;
    lc3b_word      d_grant_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    l2_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_resp    (dcache_resp),
        .dcache_rdata   (dcache_rdata),
`ifdef L2_ARB_PERF_EN
        .i_grant_count  (i_grant_count),
        .d_grant_count  (d_grant_count),
`endif
        .l2_mem_read    (l2_mem_read),
        .l2_mem_write   (l2_mem_write),
        .l2_mem_address (l2_mem_address),
        .l2_mem_wdata   (l2_mem_wdata),
        .l2_mem_resp    (l2_mem_resp),
        .l2_mem_rdata   (l2_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Finish the current grant: pulse l2_mem_resp for one cycle.
    task automatic finish_grant();
        l2_mem_resp = 1'b1;
        tick();
        l2_mem_resp = 1'b0;
        #1;
    endtask

    // One isolated transaction from either side, starting and ending in IDLE.
    task automatic lone(input bit is_i);
        if (is_i) icache_read = 1'b1; else dcache_read = 1'b1;
        tick();
        l2_mem_resp = 1'b1;
        icache_read = 1'b0;
        dcache_read = 1'b0;
        tick();
        l2_mem_resp = 1'b0;
        #1;
    endtask

    logic [15:0] order_addr [6];
    logic [15:0] pattern    [6];

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_l2_read",  l2_mem_read, 0);
        check("rst_l2_write", l2_mem_write, 0);
        check("rst_i_resp",   icache_resp, 0);
        check("rst_d_resp",   dcache_resp, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Lone I read at 0x1230, L2 answers five cycles after the grant
        icache_read = 1'b1;
        icache_address = 16'h1230;
        #1;
        check("t1_idle_read", l2_mem_read, 0);
        tick();
        check("t1_read", l2_mem_read, 1);
        check("t1_write", l2_mem_write, 0);
        check("t1_addr", l2_mem_address, 16'h1230);
        for (int i = 0; i < 4; i++) begin
            check("t1_wait_resp", icache_resp, 0);
            tick();
        end
        l2_mem_rdata = {16{8'hA5}};
        l2_mem_resp = 1'b1;
        #1;
        check("t1_i_resp", icache_resp, 1);
        check("t1_d_resp", dcache_resp, 0);
        check("t1_i_rdata", icache_rdata, {16{8'hA5}});
        check("t1_d_rdata", dcache_rdata, {16{8'hA5}});
        icache_read = 1'b0;
        tick();
        check("t1_resp_one_cycle", icache_resp, 0);
        check("t1_back_idle", l2_mem_read, 0);
        l2_mem_resp = 1'b0;
        tick();

        // Simultaneous I read 0x0040 and D write 0x8000: D first, then I
        icache_read = 1'b1;
        icache_address = 16'h0040;
        dcache_write = 1'b1;
        dcache_address = 16'h8000;
        dcache_wdata = {8{16'h1111}};
        tick();
        check("t2_d_write", l2_mem_write, 1);
        check("t2_d_read", l2_mem_read, 0);
        check("t2_d_addr", l2_mem_address, 16'h8000);
        check("t2_d_wdata", l2_mem_wdata, {8{16'h1111}});
        l2_mem_resp = 1'b1;
        #1;
        check("t2_d_resp", dcache_resp, 1);
        check("t2_i_resp_mute", icache_resp, 0);
        dcache_write = 1'b0;
        tick();
        l2_mem_resp = 1'b0;
        #1;
        check("t2_gap_read", l2_mem_read, 0);
        check("t2_gap_write", l2_mem_write, 0);
        tick();
        check("t2_i_read", l2_mem_read, 1);
        check("t2_i_addr", l2_mem_address, 16'h0040);
        check("t2_i_wdata", l2_mem_wdata, 0);
        finish_grant();
        icache_read = 1'b0;
        tick();

        // Starvation guard: D held with I pending -> D,D,D,D,I,D
        pattern[0] = 16'h0200; pattern[1] = 16'h0200; pattern[2] = 16'h0200;
        pattern[3] = 16'h0200; pattern[4] = 16'h0100; pattern[5] = 16'h0200;
        icache_read = 1'b1;
        icache_address = 16'h0100;
        dcache_read = 1'b1;
        dcache_address = 16'h0200;
        for (int g = 0; g < 6; g++) begin
            tick();
            order_addr[g] = l2_mem_address;
            finish_grant();
        end
        for (int g = 0; g < 6; g++) begin
            check($sformatf("t3_grant%0d", g), order_addr[g], pattern[g]);
        end
        icache_read = 1'b0;
        dcache_read = 1'b0;
        tick();

        // D read and write together at 0x2000: write wins
        dcache_read = 1'b1;
        dcache_write = 1'b1;
        dcache_address = 16'h2000;
        tick();
        check("t4_write", l2_mem_write, 1);
        check("t4_read_masked", l2_mem_read, 0);
        check("t4_addr", l2_mem_address, 16'h2000);
        finish_grant();
        dcache_read = 1'b0;
        dcache_write = 1'b0;
        tick();

        // Reset two cycles into an I grant; late resp must be dropped
        icache_read = 1'b1;
        icache_address = 16'h3000;
        tick();
        check("t5_granted", l2_mem_read, 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_async_read", l2_mem_read, 0);
        check("t5_async_write", l2_mem_write, 0);
        icache_read = 1'b0;
        l2_mem_resp = 1'b1;
        #1;
        check("t5_late_resp_rst", icache_resp, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t5_idle_resp_ignored", icache_resp, 0);
        check("t5_idle_dresp_ignored", dcache_resp, 0);
        tick();
        check("t5_still_idle", icache_resp, 0);
        l2_mem_resp = 1'b0;
        icache_read = 1'b1;
        tick();
        check("t5_resume", l2_mem_read, 1);
        finish_grant();
        icache_read = 1'b0;
        tick();

`ifdef L2_ARB_PERF_EN
        // One I grant since reset; add two more I and two D grants
        lone(1'b1);
        lone(1'b1);
        lone(1'b0);
        lone(1'b0);
        check("perf_i_count", i_grant_count, 16'd3);
        check("perf_d_count", d_grant_count, 16'd2);
`else
        lone(1'b0);
        check("lone_d_done", dcache_resp, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 4, meaning the maximum consecutive D-cache grants while an I-cache request waits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have ports icache_read (input, 1), icache_address (input, 16, lc3b_word), icache_resp (output, 1) and icache_rdata (output, 128, lc3b_pmem_line).
REQ-005 SHALL have ports dcache_read and dcache_write (input, 1 each), dcache_address (input, 16), dcache_wdata (input, 128), dcache_resp (output, 1) and dcache_rdata (output, 128).
REQ-006 SHALL have L2-side ports l2_mem_read and l2_mem_write (output, 1 each), l2_mem_address (output, 16), l2_mem_wdata (output, 128), l2_mem_resp (input, 1) and l2_mem_rdata (input, 128).

Function
REQ-007 SHALL implement FSM states IDLE, SERVE_I and SERVE_D, with IDLE as the reset state.
REQ-008 In IDLE, a pending request (icache_read, or dcache_read|dcache_write) SHALL be sampled and the winner's SERVE state entered on the next edge; arbitration latency is 1 cycle.
REQ-009 Winner on simultaneous requests: D-cache, unless the streak counter equals MAX_D_STREAK, in which case I-cache.
REQ-010 Streak counter: increments on each D grant made while icache_read is high; clears on any I grant or on a D grant with icache_read low; saturates at MAX_D_STREAK.
REQ-011 In SERVE_x, l2_mem_read/l2_mem_write/l2_mem_address/l2_mem_wdata SHALL combinationally forward the owner's signals; the I owner drives l2_mem_write=0 and l2_mem_wdata=0.
REQ-012 In IDLE, l2_mem_read and l2_mem_write SHALL be 0.
REQ-013 When l2_mem_resp=1 in SERVE_x, the owner's resp SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE on the next edge.
REQ-014 The non-owner's resp SHALL never be asserted; icache_resp and dcache_resp SHALL never both be 1.
REQ-015 icache_rdata and dcache_rdata SHALL both equal l2_mem_rdata at all times; validity is qualified by resp.
REQ-016 l2_mem_resp while in IDLE SHALL be ignored.
REQ-017 The grant SHALL be held until l2_mem_resp even if the owner drops its request mid-transaction, and signals continue to be forwarded as driven.
REQ-018 If dcache_read and dcache_write are both 1, write SHALL be forwarded and read masked.
REQ-019 Minimum spacing between two grants SHALL be 1 IDLE cycle; a request held through resp is re-arbitrated in that IDLE cycle.

Reset
REQ-020 When rst_n=0, the FSM SHALL enter IDLE immediately, the streak counter SHALL clear, and all resp and l2_mem_read/l2_mem_write outputs SHALL be 0 without waiting for clk.
REQ-021 Reset mid-transaction SHALL abandon the grant; no resp is issued for it.
REQ-022 Operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-023 With L2_ARB_PERF_EN defined, the block SHALL add outputs i_grant_count and d_grant_count (16 bits each, lc3b_word); each increments once per grant, wraps 0xFFFF->0x0000, and clears on reset.
REQ-024 Without L2_ARB_PERF_EN, these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 lc3b_types SHALL gain the enum lc3b_l2_arb_state (IDLE, SERVE_I, SERVE_D); lc3b_word and lc3b_pmem_line SHALL be reused from lc3b_types.
REQ-026 Sub-module l2_arb_select SHALL hold the winner logic and streak counter; FSM and muxing SHALL remain in l2_arbiter.

Verification
REQ-027 Lone I read, addr 0x1230, L2 resp after 5 cycles with rdata 0xA5..A5 -> l2_mem_read=1 from cycle 1, icache_resp=1 for exactly 1 cycle, icache_rdata matches, dcache_resp stays 0.
REQ-028 Simultaneous I read 0x0040 and D write 0x8000 (wdata 0x1111...) -> D served first with l2_mem_write=1 and addr 0x8000, then I served after 1 IDLE cycle.
REQ-029 D requests held continuously with I pending and MAX_D_STREAK=4 -> grant order D,D,D,D,I,D...
REQ-030 rst_n pulsed low 2 cycles after an I grant, before resp -> outputs go 0 asynchronously; the late l2_mem_resp produces no icache_resp.
REQ-031 D asserts read and write together at 0x2000 -> l2_mem_write=1, l2_mem_read=0; with L2_ARB_PERF_EN, 3 I grants and 2 D grants -> counts 3 and 2.
